gbus_rd_collector: RTL

//  Read-return end of the global bus. It captures per-head gbus_rdata/gbus_rvalid

---
 rtl/gbus_pkg.sv | 30 +++
 rtl/gbus_rd_fifo.sv | 60 ++++++
 rtl/gbus_rd_collector.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/gbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gbus_pkg                                                          |
// | Purpose : Shared constants, beat record and FSM state type for the global   |
// |           bus read-return collector.                                        |
// | Contents: HNUM/VNUM/GBUS_DATA geometry, HEAD_W/COL_W index widths,          |
// |           rd_beat_t {col, data}, state_e {ST_IDLE, ST_RUN}.                 |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
package gbus_pkg;

  localparam int HNUM      = 8;
  localparam int VNUM      = 8;
  localparam int GBUS_DATA = 64;
  localparam int HEAD_W    = $clog2(HNUM);
  localparam int COL_W     = $clog2(VNUM);

  // One buffered return beat: source column plus its data word.
  typedef struct packed {
    logic [COL_W-1:0]     col;
    logic [GBUS_DATA-1:0] data;
  } rd_beat_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage
`default_nettype wire

// File: rtl/gbus_rd_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gbus_rd_fifo                                                      |
// | Purpose : Synchronous FIFO of rd_beat_t for one head of the core array.     |
// | Ports   : clk, rstn (sync active-low), push/din write side,                 |
// |           pop/dout read side (dout shows the head entry), full, empty.      |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module gbus_rd_fifo
  import gbus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rstn,
  input  logic     push,
  input  rd_beat_t din,
  input  logic     pop,
  output rd_beat_t dout,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  rd_beat_t        mem_q [DEPTH];
  logic [AW:0]     wr_ptr_q, wr_ptr_d;
  logic [AW:0]     rd_ptr_q, rd_ptr_d;
  logic            wr_en;
  logic            rd_en;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    rd_en    = pop & ~empty;
    // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
    wr_en    = push & (~full | rd_en);
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, rd_en};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= din;
  end

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

endmodule
`default_nettype wire

// File: rtl/gbus_rd_collector.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : gbus_rd_collector                                                 |
// | Purpose : Read-return end of the global bus. Captures per-head returns into |
// |           per-head FIFOs, merges them round-robin into one tagged stream,   |
// |           and counts accepted beats against a programmed total.             |
// | Ports   : clk, rstn (sync active-low); start/cfg_beat_num control;          |
// |           gbus_rdata/gbus_rvalid capture; out_valid/out_ready/out_data/     |
// |           out_head/out_col stream; busy, done, err_overflow, err_multi.     |
// | Revision: 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
module gbus_rd_collector
  import gbus_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      start,
  input  logic [CNT_W-1:0]          cfg_beat_num,
  input  logic [HNUM*GBUS_DATA-1:0] gbus_rdata,
  input  logic [HNUM*VNUM-1:0]      gbus_rvalid,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [GBUS_DATA-1:0]      out_data,
  output logic [HEAD_W-1:0]         out_head,
  output logic [COL_W-1:0]          out_col,
  output logic                      busy,
  output logic                      done,
  output logic [HNUM-1:0]           err_overflow,
  output logic [HNUM-1:0]           err_multi
);

  rd_beat_t          push_beat [HNUM];
  rd_beat_t          fifo_dout [HNUM];
  logic [HNUM-1:0]   push, pop, fifo_full, fifo_empty, multi;

  // ---------------- capture and per-head buffering ----------------
  for (genvar h = 0; h < HNUM; h++) begin : g_head
    logic [VNUM-1:0]  rv;
    logic [COL_W-1:0] col;

    assign rv = gbus_rvalid[h*VNUM +: VNUM];

    // Descending scan so the lowest set bit is the final assignment.
    always_comb begin
      col = '0;
      for (int v = VNUM-1; v >= 0; v--) begin
        if (rv[v]) col = COL_W'(v);
      end
    end

    assign push[h]           = |rv;
    assign multi[h]          = |(rv & (rv - 1'b1));
    assign push_beat[h].col  = col;
    assign push_beat[h].data = gbus_rdata[h*GBUS_DATA +: GBUS_DATA];

    gbus_rd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rstn  (rstn),
      .push  (push[h]),
      .din   (push_beat[h]),
      .pop   (pop[h]),
      .dout  (fifo_dout[h]),
      .full  (fifo_full[h]),
      .empty (fifo_empty[h])
    );
  end

  // ---------------- arbiter and output register ----------------
  logic [HEAD_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic                 out_valid_q, out_valid_d;
  logic [GBUS_DATA-1:0] out_data_q, out_data_d;
  logic [HEAD_W-1:0]    out_head_q, out_head_d;
  logic [COL_W-1:0]     out_col_q, out_col_d;
  logic [HNUM-1:0]      err_overflow_q, err_overflow_d;
  logic [HNUM-1:0]      err_multi_q, err_multi_d;
  logic                 out_free, req_vld, grant;
  logic [HEAD_W-1:0]    grant_idx, cand;
  int                   cand_i;

  always_comb begin
    out_free  = ~out_valid_q | out_ready;
    req_vld   = 1'b0;
    grant_idx = '0;
    cand_i    = 0;
    cand      = '0;
    // Walk from the farthest offset back to the pointer so the nearest
    // non-empty head after rr_ptr_q wins.
    for (int k = HNUM-1; k >= 0; k--) begin
      cand_i = (int'(rr_ptr_q) + k) % HNUM;
      cand   = HEAD_W'(cand_i);
      if (!fifo_empty[cand]) begin
        req_vld   = 1'b1;
        grant_idx = cand;
      end
    end
    grant = req_vld & out_free;
    pop   = '0;
    if (grant) pop[grant_idx] = 1'b1;

    rr_ptr_d    = grant ? HEAD_W'((int'(grant_idx) + 1) % HNUM) : rr_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_head_d  = out_head_q;
    out_col_d   = out_col_q;
    if (grant) begin
      out_valid_d = 1'b1;
      out_data_d  = fifo_dout[grant_idx].data;
      out_head_d  = grant_idx;
      out_col_d   = fifo_dout[grant_idx].col;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    err_overflow_d = err_overflow_q | (push & fifo_full & ~pop);
    err_multi_d    = err_multi_q | multi;
  end

  // ---------------- beat counting FSM ----------------
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tgt_q, tgt_d;
  logic             done_q, done_d;
  logic             accept;

  always_comb begin
    accept  = out_valid_q & out_ready;
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_beat_num == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RUN;
            cnt_d   = '0;
            tgt_d   = cfg_beat_num;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          if (cnt_q == tgt_q - CNT_W'(1)) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rr_ptr_q       <= '0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_head_q     <= '0;
      out_col_q      <= '0;
      err_overflow_q <= '0;
      err_multi_q    <= '0;
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tgt_q          <= '0;
      done_q         <= 1'b0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      out_valid_q    <= out_valid_d;
      out_data_q     <= out_data_d;
      out_head_q     <= out_head_d;
      out_col_q      <= out_col_d;
      err_overflow_q <= err_overflow_d;
      err_multi_q    <= err_multi_d;
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      tgt_q          <= tgt_d;
      done_q         <= done_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_head     = out_head_q;
  assign out_col      = out_col_q;
  assign busy         = (state_q == ST_RUN);
  assign done         = done_q;
  assign err_overflow = err_overflow_q;
  assign err_multi    = err_multi_q;

endmodule
`default_nettype wire
